l15_port_arbiter: RTL and testbench

//  Shares the core's single L1.5 transducer port between the instruction-fetch requester (port I)
//  and the data-memory requester (port D). One transaction in flight at a time, held from grant to response.

---
 rtl/l15_pkg.sv | 22 ++
 rtl/l15_req_reg.sv | 33 +++
 rtl/l15_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_l15_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_pkg.sv
// Shared types and L1.5 request-type encodings for the core's
// single transducer port.
package l15_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;
    localparam logic [4:0] RQ_IMISS = 5'b10000;

    localparam int L15_ADDR_W = 40;

endpackage

// File: rtl/l15_req_reg.sv
// Request-field latch: captures the granted requester's fields on load
// and holds them stable for the L1.5 until the next grant.
module l15_req_reg
    import l15_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4:0]            rqtype,
    input  logic [2:0]            size,
    input  logic [L15_ADDR_W-1:0] address,
    input  logic [63:0]           data,
    output logic [4:0]            rqtype_q,
    output logic [2:0]            size_q,
    output logic [L15_ADDR_W-1:0] address_q,
    output logic [63:0]           data_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rqtype_q  <= '0;
            size_q    <= '0;
            address_q <= '0;
            data_q    <= '0;
        end else if (load) begin
            rqtype_q  <= rqtype;
            size_q    <= size;
            address_q <= address;
            data_q    <= data;
        end
    end

endmodule

// File: rtl/l15_port_arbiter.sv
// Shares the L1.5 transducer port between fetch (I) and data (D),
// one transaction in flight, data priority with fetch anti-starvation.
module l15_port_arbiter
    import l15_pkg::*;
#(
    parameter int REQ_ADDR_W     = 32,
    parameter int MEM_BURST_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_l15_val,
    input  logic [4:0]            instr_l15_rqtype,
    input  logic [2:0]            instr_l15_size,
    input  logic [REQ_ADDR_W-1:0] instr_l15_address,
    input  logic [63:0]           instr_l15_data,
    input  logic                  instr_l15_req_ack,
    input  logic                  mem_l15_val,
    input  logic [4:0]            mem_l15_rqtype,
    input  logic [2:0]            mem_l15_size,
    input  logic [REQ_ADDR_W-1:0] mem_l15_address,
    input  logic [63:0]           mem_l15_data,
    input  logic                  mem_l15_req_ack,
    output logic                  l15_instr_header_ack,
    output logic                  l15_mem_header_ack,
    output logic                  l15_instr_val,
    output logic                  l15_mem_val,
    output logic                  l15_instr_ack,
    output logic                  l15_mem_ack,
    output logic [63:0]           l15_resp_data_0,
    output logic [63:0]           l15_resp_data_1,
    output logic [3:0]            l15_resp_returntype,
    output logic                  transducer_l15_val,
    output logic [4:0]            transducer_l15_rqtype,
    output logic [2:0]            transducer_l15_size,
    output logic [39:0]           transducer_l15_address,
    output logic [63:0]           transducer_l15_data,
    output logic                  transducer_l15_req_ack,
    input  logic                  l15_transducer_header_ack,
    input  logic                  l15_transducer_val,
    input  logic                  l15_transducer_ack,
    input  logic [63:0]           l15_transducer_data_0,
    input  logic [63:0]           l15_transducer_data_1,
    input  logic [3:0]            l15_transducer_returntype,
    output logic                  owner_is_mem,
    output logic                  fetch_stall,
    output logic                  timeout_err
);

    localparam int BW = (MEM_BURST_MAX < 1) ? 1 : $clog2(MEM_BURST_MAX + 1);
    localparam int WW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BMAX = BW'(MEM_BURST_MAX);
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT_CYCLES);

    arb_state_t    state, state_nxt;
    owner_t        owner, owner_nxt;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wdog;
    logic [WW-1:0] wdog_inc;
    logic          grant_d;
    logic          grant_i;
    logic          load;
    logic          in_idle;
    logic          in_req;
    logic          in_resp;
    logic          own_d;
    logic          resp_in;
    logic          own_req_ack;

    assign in_idle     = (state == ARB_IDLE);
    assign in_req      = (state == ARB_REQ);
    assign in_resp     = (state == ARB_RESP);
    assign own_d       = (owner == OWN_D);
    assign resp_in     = l15_transducer_val || l15_transducer_ack;
    assign own_req_ack = own_d ? mem_l15_req_ack : instr_l15_req_ack;
    assign wdog_inc    = wdog + 1'b1;

    // Fetch overrides data only once D has taken BMAX grants over it.
    assign grant_d = mem_l15_val && !(instr_l15_val && burst_cnt == BMAX);
    assign grant_i = instr_l15_val && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= OWN_I;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        load      = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (grant_d || grant_i) begin
                    state_nxt = ARB_REQ;
                    owner_nxt = grant_d ? OWN_D : OWN_I;
                    load      = 1'b1;
                end
            end
            ARB_REQ: begin
                if (l15_transducer_header_ack) state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                if (resp_in && own_req_ack) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !instr_l15_val) begin
            burst_cnt <= '0;
        end else if (in_idle && grant_i) begin
            burst_cnt <= '0;
        end else if (in_idle && grant_d && burst_cnt != BMAX) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Flag lands on the same edge wdog reaches TMAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else if (!in_resp) begin
            wdog <= '0;
        end else begin
            if (wdog != TMAX) wdog <= wdog_inc;
            if (TIMEOUT_CYCLES != 0 && wdog != TMAX && wdog_inc == TMAX)
                timeout_err <= 1'b1;
        end
    end

    l15_req_reg u_req_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .rqtype    (grant_d ? mem_l15_rqtype : instr_l15_rqtype),
        .size      (grant_d ? mem_l15_size : instr_l15_size),
        .address   (40'(grant_d ? mem_l15_address : instr_l15_address)),
        .data      (grant_d ? mem_l15_data : instr_l15_data),
        .rqtype_q  (transducer_l15_rqtype),
        .size_q    (transducer_l15_size),
        .address_q (transducer_l15_address),
        .data_q    (transducer_l15_data)
    );

    assign transducer_l15_val   = in_req;
    assign l15_instr_header_ack = in_req && !own_d && l15_transducer_header_ack;
    assign l15_mem_header_ack   = in_req && own_d && l15_transducer_header_ack;

    assign l15_instr_val = in_resp && !own_d && l15_transducer_val;
    assign l15_instr_ack = in_resp && !own_d && l15_transducer_ack;
    assign l15_mem_val   = in_resp && own_d && l15_transducer_val;
    assign l15_mem_ack   = in_resp && own_d && l15_transducer_ack;

    assign l15_resp_data_0     = in_resp ? l15_transducer_data_0 : '0;
    assign l15_resp_data_1     = in_resp ? l15_transducer_data_1 : '0;
    assign l15_resp_returntype = in_resp ? l15_transducer_returntype : '0;

    assign transducer_l15_req_ack = in_resp && resp_in && own_req_ack;

    assign owner_is_mem = !in_idle && own_d;
    assign fetch_stall  = mem_l15_val || owner_is_mem;

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Scoreboard bench for l15_port_arbiter: expected grants are queued
// as requests are raised and checked as the L1.5 side sees them.
module tb_l15_port_arbiter;
    import l15_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_l15_val, mem_l15_val;
    logic [4:0]  instr_l15_rqtype, mem_l15_rqtype;
    logic [2:0]  instr_l15_size, mem_l15_size;
    logic [31:0] instr_l15_address, mem_l15_address;
    logic [63:0] instr_l15_data, mem_l15_data;
    logic        instr_l15_req_ack, mem_l15_req_ack;
    logic        l15_instr_header_ack, l15_mem_header_ack;
    logic        l15_instr_val, l15_mem_val, l15_instr_ack, l15_mem_ack;
    logic [63:0] l15_resp_data_0, l15_resp_data_1;
    logic [3:0]  l15_resp_returntype;
    logic        transducer_l15_val;
    logic [4:0]  transducer_l15_rqtype;
    logic [2:0]  transducer_l15_size;
    logic [39:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;
    logic        transducer_l15_req_ack;
    logic        l15_transducer_header_ack, l15_transducer_val;
    logic        l15_transducer_ack;
    logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
    logic [3:0]  l15_transducer_returntype;
    logic        owner_is_mem, fetch_stall, timeout_err;

    typedef struct packed {
        logic        mem;
        logic [39:0] addr;
        logic [4:0]  rqtype;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    l15_port_arbiter #(
        .REQ_ADDR_W     (32),
        .MEM_BURST_MAX  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .instr_l15_val             (instr_l15_val),
        .instr_l15_rqtype          (instr_l15_rqtype),
        .instr_l15_size            (instr_l15_size),
        .instr_l15_address         (instr_l15_address),
        .instr_l15_data            (instr_l15_data),
        .instr_l15_req_ack         (instr_l15_req_ack),
        .mem_l15_val               (mem_l15_val),
        .mem_l15_rqtype            (mem_l15_rqtype),
        .mem_l15_size              (mem_l15_size),
        .mem_l15_address           (mem_l15_address),
        .mem_l15_data              (mem_l15_data),
        .mem_l15_req_ack           (mem_l15_req_ack),
        .l15_instr_header_ack      (l15_instr_header_ack),
        .l15_mem_header_ack        (l15_mem_header_ack),
        .l15_instr_val             (l15_instr_val),
        .l15_mem_val               (l15_mem_val),
        .l15_instr_ack             (l15_instr_ack),
        .l15_mem_ack               (l15_mem_ack),
        .l15_resp_data_0           (l15_resp_data_0),
        .l15_resp_data_1           (l15_resp_data_1),
        .l15_resp_returntype       (l15_resp_returntype),
        .transducer_l15_val        (transducer_l15_val),
        .transducer_l15_rqtype     (transducer_l15_rqtype),
        .transducer_l15_size       (transducer_l15_size),
        .transducer_l15_address    (transducer_l15_address),
        .transducer_l15_data       (transducer_l15_data),
        .transducer_l15_req_ack    (transducer_l15_req_ack),
        .l15_transducer_header_ack (l15_transducer_header_ack),
        .l15_transducer_val        (l15_transducer_val),
        .l15_transducer_ack        (l15_transducer_ack),
        .l15_transducer_data_0     (l15_transducer_data_0),
        .l15_transducer_data_1     (l15_transducer_data_1),
        .l15_transducer_returntype (l15_transducer_returntype),
        .owner_is_mem              (owner_is_mem),
        .fetch_stall               (fetch_stall),
        .timeout_err               (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] all_outs();
        return 256'({l15_instr_header_ack, l15_mem_header_ack,
                     l15_instr_val, l15_mem_val, l15_instr_ack,
                     l15_mem_ack, l15_resp_data_0, l15_resp_data_1,
                     l15_resp_returntype, transducer_l15_val,
                     transducer_l15_rqtype, transducer_l15_size,
                     transducer_l15_address, transducer_l15_req_ack,
                     owner_is_mem, fetch_stall, timeout_err});
    endfunction

    task automatic idle_inputs();
        instr_l15_val = 0; mem_l15_val = 0;
        instr_l15_rqtype = RQ_IMISS; mem_l15_rqtype = RQ_LOAD;
        instr_l15_size = 3'd4; mem_l15_size = 3'd3;
        instr_l15_address = '0; mem_l15_address = '0;
        instr_l15_data = '0; mem_l15_data = '0;
        instr_l15_req_ack = 0; mem_l15_req_ack = 0;
        l15_transducer_header_ack = 0; l15_transducer_val = 0;
        l15_transducer_ack = 0; l15_transducer_returntype = '0;
        l15_transducer_data_0 = '0; l15_transducer_data_1 = '0;
    endtask

    // Plays the L1.5 and the owning requester for one transaction.
    task automatic serve(input int hdr_dly, input int rsp_dly,
                         input bit ack_only, input bit drop_val);
        exp_t       e;
        int         n;
        logic [3:0] exp_g;
        logic [63:0] d0;
        n = 0;
        while (transducer_l15_val !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_bad++;
            $display("FAIL wait_req: transducer_l15_val never rose");
            return;
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty: grant with no expected entry");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (transducer_l15_address !== e.addr) begin
            n_bad++;
            $display("FAIL addr: got %h want %h",
                     transducer_l15_address, e.addr);
        end
        n_cmp++;
        if (owner_is_mem !== e.mem) begin
            n_bad++;
            $display("FAIL owner: got %b want %b", owner_is_mem, e.mem);
        end
        n_cmp++;
        if (transducer_l15_rqtype !== e.rqtype) begin
            n_bad++;
            $display("FAIL rqtype: got %h want %h",
                     transducer_l15_rqtype, e.rqtype);
        end
        repeat (hdr_dly) step();
        l15_transducer_header_ack = 1;
        #1;
        n_cmp++;
        if ({l15_mem_header_ack, l15_instr_header_ack} !==
            (e.mem ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL hdr_ack: got %b want %b",
                     {l15_mem_header_ack, l15_instr_header_ack},
                     (e.mem ? 2'b10 : 2'b01));
        end
        step();
        l15_transducer_header_ack = 0;
        if (drop_val) begin
            if (e.mem) mem_l15_val = 0;
            else instr_l15_val = 0;
        end
        #1;
        n_cmp++;
        if ({transducer_l15_val, l15_mem_header_ack,
             l15_instr_header_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL req_drop: val/hdr got %b want 000",
                     {transducer_l15_val, l15_mem_header_ack,
                      l15_instr_header_ack});
        end
        repeat (rsp_dly) step();
        d0 = {32'hD0D0_0000, 7'd0, e.addr[24:0]};
        l15_transducer_data_0 = d0;
        l15_transducer_returntype = 4'h5;
        if (ack_only) l15_transducer_ack = 1;
        else l15_transducer_val = 1;
        #1;
        exp_g = {e.mem & ~ack_only, e.mem & ack_only,
                 ~e.mem & ~ack_only, ~e.mem & ack_only};
        n_cmp++;
        if ({l15_mem_val, l15_mem_ack, l15_instr_val, l15_instr_ack}
            !== exp_g) begin
            n_bad++;
            $display("FAIL gate: got %b want %b",
                     {l15_mem_val, l15_mem_ack, l15_instr_val,
                      l15_instr_ack}, exp_g);
        end
        n_cmp++;
        if (transducer_l15_req_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL req_ack_early: got %b want 0",
                     transducer_l15_req_ack);
        end
        n_cmp++;
        if (l15_resp_data_0 !== d0) begin
            n_bad++;
            $display("FAIL data0: got %h want %h", l15_resp_data_0, d0);
        end
        if (e.mem) mem_l15_req_ack = 1;
        else instr_l15_req_ack = 1;
        #1;
        n_cmp++;
        if (transducer_l15_req_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL req_ack: got %b want 1", transducer_l15_req_ack);
        end
        step();
        l15_transducer_val = 0;
        l15_transducer_ack = 0;
        mem_l15_req_ack = 0;
        instr_l15_req_ack = 0;
        #1;
        n_cmp++;
        if ({transducer_l15_val, l15_mem_val, l15_instr_val,
             transducer_l15_req_ack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL dead_cycle: got %b want 0000",
                     {transducer_l15_val, l15_mem_val, l15_instr_val,
                      transducer_l15_req_ack});
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) step();
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        rst = 0;
        step();
    endtask

    task automatic test_instr_alone();
        instr_l15_address = 32'h0000_1000;
        instr_l15_val = 1;
        sb.push_back('{1'b0, 40'h00_0000_1000, RQ_IMISS});
        step();
        n_cmp++;
        if (transducer_l15_val !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_lat: val got %b want 1",
                     transducer_l15_val);
        end
        serve(2, 2, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        instr_l15_address = 32'h0000_2040;
        mem_l15_address = 32'hFFFF_F000;
        mem_l15_rqtype = RQ_LOAD;
        sb.push_back('{1'b1, 40'h00_FFFF_F000, RQ_LOAD});
        sb.push_back('{1'b0, 40'h00_0000_2040, RQ_IMISS});
        instr_l15_val = 1;
        mem_l15_val = 1;
        #1;
        n_cmp++;
        if (fetch_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL stall: got %b want 1", fetch_stall);
        end
        serve(1, 1, 1'b0, 1'b1);
        serve(1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_burst();
        instr_l15_address = 32'h0000_3000;
        mem_l15_address = 32'h0000_8000;
        repeat (4) sb.push_back('{1'b1, 40'h00_0000_8000, RQ_LOAD});
        sb.push_back('{1'b0, 40'h00_0000_3000, RQ_IMISS});
        sb.push_back('{1'b1, 40'h00_0000_8000, RQ_LOAD});
        instr_l15_val = 1;
        mem_l15_val = 1;
        repeat (4) serve(0, 1, 1'b0, 1'b0);
        serve(0, 1, 1'b0, 1'b1);
        serve(0, 1, 1'b0, 1'b1);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_left: got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_store_ack();
        mem_l15_address = 32'h0000_00C0;
        mem_l15_rqtype = RQ_STORE;
        mem_l15_data = 64'hCAFE_F00D_1234_5678;
        sb.push_back('{1'b1, 40'h00_0000_00C0, RQ_STORE});
        mem_l15_val = 1;
        step();
        n_cmp++;
        if (transducer_l15_data !== 64'hCAFE_F00D_1234_5678) begin
            n_bad++;
            $display("FAIL st_data: got %h want cafef00d12345678",
                     transducer_l15_data);
        end
        serve(1, 2, 1'b1, 1'b1);
    endtask

    task automatic test_timeout_and_rst();
        int n;
        mem_l15_address = 32'h0000_0400;
        mem_l15_rqtype = RQ_LOAD;
        mem_l15_val = 1;
        n = 0;
        while (transducer_l15_val !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        l15_transducer_header_ack = 1;
        step();
        l15_transducer_header_ack = 0;
        mem_l15_val = 0;
        repeat (7) step();
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_early: got %b want 0", timeout_err);
        end
        step();
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_rise: got %b want 1", timeout_err);
        end
        repeat (5) step();
        n_cmp++;
        if (timeout_err !== 1'b1 || owner_is_mem !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_sticky: err/own got %b%b want 11",
                     timeout_err, owner_is_mem);
        end
        rst = 1;
        step();
        n_cmp++;
        if (all_outs() !== '0) begin
            n_bad++;
            $display("FAIL rst_resp: got %h want 0", all_outs());
        end
        rst = 0;
        l15_transducer_val = 1;
        l15_transducer_data_0 = 64'h1111_2222_3333_4444;
        mem_l15_req_ack = 1;
        step();
        n_cmp++;
        if ({l15_mem_val, l15_instr_val, transducer_l15_req_ack,
             timeout_err} !== 4'b0000 || l15_resp_data_0 !== '0) begin
            n_bad++;
            $display("FAIL late_resp: got %b data %h want 0000 data 0",
                     {l15_mem_val, l15_instr_val, transducer_l15_req_ack,
                      timeout_err}, l15_resp_data_0);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_instr_alone();
        test_simultaneous();
        test_burst();
        test_store_ack();
        test_timeout_and_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
